uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It accepts one byte per receiver handshake and stores up to 2^DEPTH_LOG2 bytes. It presents them first-word-fall-through to the CPU-side consumer with a valid/ready handshake. Because it is always ready when out of reset, the receiver never stalls in its data state and never loses start-bit framing; bytes arriving while the buffer is full are dropped and flagged.

## Interface
- DEPTH_LOG2, 4, log2 of buffer depth (DEPTH = 16 bytes by default); legal range 2..8
- AFULL_MARGIN, 2, almost_full asserts when level >= DEPTH - AFULL_MARGIN
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high; one clock, one synchronous active-high reset
- in_data  input  8  byte from receiver (rx_data)
- in_valid  input  1  receiver byte valid (rx_data_valid)
- in_ready  output  1  to receiver rx_data_ready; 0 during reset, 1 otherwise (even when full)
- out_data  output  8  oldest stored byte; valid only while out_valid
- out_valid  output  1  buffer non-empty
- out_ready  input  1  consumer takes out_data this cycle
- flush  input  1  synchronous discard of all stored bytes
- level  output  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH
- almost_full  output  1  level >= DEPTH - AFULL_MARGIN
- overflow  output  1  sticky: a byte was dropped because the buffer was full
- ovf_clr  input  1  clears overflow (and ovf_count)
- ovf_count  output  8  dropped-byte counter (see Configuration)

## Operation
- Storage: DEPTH x 8 register array; write pointer wr_ptr and read pointer rd_ptr of DEPTH_LOG2 bits, wrapping modulo DEPTH; level held as separate DEPTH_LOG2+1-bit counter.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- push with level < DEPTH: mem[wr_ptr] <= in_data, wr_ptr++.
- push with level == DEPTH and no pop: byte dropped, pointers/level unchanged, overflow <= 1.
- push with level == DEPTH and pop same cycle: push accepted (slot freed by pop), level stays DEPTH, no overflow.
- pop: rd_ptr++; level-- unless simultaneous accepted push (level unchanged).
- out_valid = (level != 0); out_data = mem[rd_ptr] (combinational read of array).
- flush: wr_ptr, rd_ptr, level <= 0; takes priority over push and pop in the same cycle (that push is discarded, not counted as overflow). overflow and ovf_count unaffected.
- ovf_clr: overflow <= 0; if same cycle as a dropping push, set wins (overflow stays 1).
- No FSM beyond the pointer/level counters; the only control state is the reset-gated in_ready flop.

## Timing
- Reset values: in_ready 0, out_valid 0, level 0, almost_full 0, overflow 0, ovf_count 0, out_data 0 (array cleared or read masked to 0 while empty is not required; out_data is don't-care when out_valid is 0).
- in_ready rises on the first clock edge after rst deasserts.
- Latency: byte pushed at edge N -> out_valid/out_data visible after edge N (cycle N+1) if buffer was empty.
- Sustained throughput one push and one pop per clock.
- level, almost_full, overflow all registered; update on the edge of the causing handshake.
- rst asserted mid-operation: all contents discarded on that edge; a concurrent push is lost.

## Configuration
- UART_RX_FIFO_OVF_CNT_EN defined: ovf_count increments on every dropped byte, saturates at 255, clears on rst or ovf_clr (increment wins over clear in the same cycle, giving 1).
- Not defined: ovf_count port present, driven constant 8'd0; counter logic absent. overflow flag behaves identically in both builds.

## Test plan
- Reset then push 0x41,0x42,0x43 with out_ready=0 -> level=3, out_valid=1, out_data=0x41; then out_ready=1 three cycles -> 0x41,0x42,0x43 in order, level=0, out_valid=0.
- Push 16 bytes 0x00..0x0F, out_ready=0 -> level=16, almost_full set at level 14; 17th push 0xAA -> dropped, overflow=1, ovf_count=1 (macro on) / 0 (off); drain yields 0x00..0x0F.
- Full buffer, push 0x55 with pop same cycle -> level stays 16, no overflow, 0x55 emerges last after 15 further pops.
- Push/pop continuously for 40 bytes (pointer wrap x2) -> output sequence equals input, level never exceeds 1.
- flush with simultaneous push at level 5 -> level=0, out_valid=0, overflow unchanged; ovf_clr with dropping push -> overflow stays 1.
- 20 drops with macro on, ovf_clr, then 300 drops -> ovf_count 20, then 0, then saturates at 255.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer between the UART receiver and the CPU-side
// consumer. Stores up to 2**DEPTH_LOG2 bytes and presents them
// first-word-fall-through with a valid/ready handshake. The buffer is
// always ready out of reset, so the receiver never stalls. Bytes that
// arrive while it is full are dropped and flagged.
//
// Optional feature: define UART_RX_FIFO_OVF_CNT_EN to build the saturating
// dropped-byte counter behind ovf_count. Without it, ovf_count is tied to 0.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_data      byte from receiver
//   in_valid     receiver byte valid
//   in_ready     to receiver: 0 in reset, 1 otherwise (even when full)
//   out_data     oldest stored byte (meaningful while out_valid)
//   out_valid    buffer non-empty
//   out_ready    consumer takes out_data this cycle
//   flush        discard all stored bytes
//   level        number of stored bytes, 0..DEPTH
//   almost_full  level >= DEPTH - AFULL_MARGIN
//   overflow     sticky: a byte was dropped while full
//   ovf_clr      clears overflow and ovf_count
//   ovf_count    dropped-byte counter (0 when the counter is not built)
module uart_rx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [7:0]            ovf_count
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_L  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   AFULL_TH = (DEPTH_LOG2 + 1)'(DEPTH - AFULL_MARGIN);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  in_ready_r;
  logic                  almost_full_r;
  logic                  overflow_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  accept_s;
  logic                  drop_s;
  logic [DEPTH_LOG2:0]   level_nxt_s;

  assign out_valid   = (level_r != {(DEPTH_LOG2 + 1){1'b0}});
  assign out_data    = mem_r[rd_ptr_r];
  assign in_ready    = in_ready_r;
  assign level       = level_r;
  assign almost_full = almost_full_r;
  assign overflow    = overflow_r;

  // Handshake decode; flush overrides both push and pop, and a push into a
  // full buffer is only accepted when a pop frees the slot in the same cycle.
  always_comb begin
    push_s   = in_valid & in_ready_r;
    pop_s    = out_valid & out_ready;
    full_s   = (level_r == DEPTH_L);
    accept_s = push_s & (~full_s | pop_s) & ~flush;
    drop_s   = push_s & full_s & ~pop_s & ~flush;
    if (flush) begin
      level_nxt_s = {(DEPTH_LOG2 + 1){1'b0}};
    end else if (accept_s && !pop_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (pop_s && !accept_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Storage array; contents need no reset because out_data is ignored while empty.
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers, level, almost_full, in_ready and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r      <= {DEPTH_LOG2{1'b0}};
      level_r       <= {(DEPTH_LOG2 + 1){1'b0}};
      almost_full_r <= 1'b0;
      in_ready_r    <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      in_ready_r    <= 1'b1;
      level_r       <= level_nxt_s;
      almost_full_r <= (level_nxt_s >= AFULL_TH);
      if (flush) begin
        wr_ptr_r <= {DEPTH_LOG2{1'b0}};
        rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      end else begin
        if (accept_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      // A drop in the same cycle as ovf_clr keeps the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_count_r;

  assign ovf_count = ovf_count_r;

  // Saturating dropped-byte counter; a drop together with ovf_clr restarts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count_r <= 8'd0;
    end else if (drop_s) begin
      if (ovf_clr) begin
        ovf_count_r <= 8'd1;
      end else if (ovf_count_r != 8'hFF) begin
        ovf_count_r <= ovf_count_r + 8'd1;
      end
    end else if (ovf_clr) begin
      ovf_count_r <= 8'd0;
    end
  end
`else
  assign ovf_count = 8'd0;
`endif

endmodule
